// File: rtl/tt_spi_pkg.sv
// Shared types and constants for the TinyTapeout SPI register target.
package tt_spi_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StCmd,
      StData
   } state_e;

   localparam int unsigned RW_BIT = 7;
   localparam int unsigned ADDR_W = 7;
   localparam int unsigned BYTE_W = 8;

   function automatic logic addr_in_range(logic [ADDR_W-1:0] addr, int unsigned num_regs);
      return 32'(addr) < num_regs;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall pulses; level is aligned with the pulses.
module spi_sync_edge #(
   parameter int unsigned STAGES    = 2,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;
   logic              rise_q;
   logic              fall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         prev_q <= sync_q[STAGES-1];
         rise_q <= sync_q[STAGES-1] & ~prev_q;
         fall_q <= ~sync_q[STAGES-1] & prev_q;
      end
   end

   assign level = prev_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/tt_spi_reg_target.sv
// SPI mode-0 target with a byte-wide register file and burst addressing.
module tt_spi_reg_target
   import tt_spi_pkg::*;
#(
   parameter int unsigned NUM_REGS    = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sclk_i,
   input  logic                       cs_n_i,
   input  logic                       mosi_i,
   output logic                       miso_o,
   output logic                       miso_oe_o,
   output logic [NUM_REGS*BYTE_W-1:0] regs_o,
   output logic                       wr_strobe_o,
   output logic [ADDR_W-1:0]          wr_addr_o
);

   localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;
   logic unused_sync;

   // cs_n chain resets to "selected" so a reset with cs_n held low never looks like a new frame.
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (sclk_i),
      .level (sclk_lvl),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (cs_n_i),
      .level (cs_lvl),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (mosi_i),
      .level (mosi_lvl),
      .rise  (mosi_rise),
      .fall  (mosi_fall)
   );

   assign unused_sync = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

   state_e              state_q;
   logic [2:0]          bit_cnt_q;
   logic [BYTE_W-2:0]   shift_in_q;
   logic [BYTE_W-1:0]   shift_out_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                write_q;
   logic [BYTE_W-1:0]   regs_q [NUM_REGS];
   logic                wr_strobe_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic                miso_oe_q;

   logic [BYTE_W-1:0]   byte_in;
   logic                byte_done;
   logic [ADDR_W-1:0]   load_addr;
   logic [BYTE_W-1:0]   load_data;

   always_comb begin
      byte_in   = {shift_in_q, mosi_lvl};
      byte_done = (bit_cnt_q == 3'd7);
      load_addr = (state_q == StCmd) ? byte_in[ADDR_W-1:0] : addr_q + 7'd1;
      load_data = '0;
      if (addr_in_range(load_addr, NUM_REGS)) begin
         load_data = regs_q[load_addr[IDX_W-1:0]];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         shift_in_q  <= '0;
         shift_out_q <= '0;
         addr_q      <= '0;
         write_q     <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         miso_oe_q   <= 1'b0;
         for (int k = 0; k < NUM_REGS; k++) begin
            regs_q[k] <= '0;
         end
      end else begin
         wr_strobe_q <= 1'b0;
         if (cs_rise) begin
            // Deselect overrides any simultaneous sclk edge and drops a partial byte.
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shift_out_q <= '0;
            miso_oe_q   <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (cs_fall) begin
                     state_q     <= StCmd;
                     bit_cnt_q   <= '0;
                     shift_out_q <= '0;
                     miso_oe_q   <= 1'b1;
                  end
               end
               StCmd: begin
                  if (sclk_rise) begin
                     shift_in_q <= byte_in[BYTE_W-2:0];
                     bit_cnt_q  <= bit_cnt_q + 3'd1;
                     if (byte_done) begin
                        state_q     <= StData;
                        write_q     <= byte_in[RW_BIT];
                        addr_q      <= byte_in[ADDR_W-1:0];
                        shift_out_q <= byte_in[RW_BIT] ? '0 : load_data;
                     end
                  end
               end
               StData: begin
                  if (sclk_rise) begin
                     shift_in_q <= byte_in[BYTE_W-2:0];
                     bit_cnt_q  <= bit_cnt_q + 3'd1;
                     if (byte_done) begin
                        addr_q <= addr_q + 7'd1;
                        if (write_q) begin
                           if (addr_in_range(addr_q, NUM_REGS)) begin
                              regs_q[addr_q[IDX_W-1:0]] <= byte_in;
                              wr_strobe_q               <= 1'b1;
                              wr_addr_q                 <= addr_q;
                           end
                        end else begin
                           shift_out_q <= load_data;
                        end
                     end
                  end else if (sclk_fall && !write_q && bit_cnt_q != 3'd0) begin
                     // Bit 7 of a freshly loaded byte must survive the fall that follows the load.
                     shift_out_q <= {shift_out_q[BYTE_W-2:0], 1'b0};
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   always_comb begin
      regs_o = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         regs_o[k*BYTE_W +: BYTE_W] = regs_q[k];
      end
   end

   assign miso_o      = shift_out_q[BYTE_W-1];
   assign miso_oe_o   = miso_oe_q;
   assign wr_strobe_o = wr_strobe_q;
   assign wr_addr_o   = wr_addr_q;

endmodule

// File: tb/tb_tt_spi_reg_target.sv
// Directed and randomized SPI transactions checked against a byte-array register model.
module tb_tt_spi_reg_target;

   localparam int NR   = 8;
   localparam int HALF = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          sclk = 1'b0;
   logic          cs_n = 1'b1;
   logic          mosi = 1'b0;
   logic          miso;
   logic          miso_oe;
   logic [NR*8-1:0] regs;
   logic          wr_strobe;
   logic [6:0]    wr_addr;

   always #5 clk = ~clk;

   tt_spi_reg_target #(.NUM_REGS(NR), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sclk_i      (sclk),
      .cs_n_i      (cs_n),
      .mosi_i      (mosi),
      .miso_o      (miso),
      .miso_oe_o   (miso_oe),
      .regs_o      (regs),
      .wr_strobe_o (wr_strobe),
      .wr_addr_o   (wr_addr)
   );

   int checks = 0;
   int failures = 0;
   logic [7:0]  model [128];
   logic [7:0]  buf_d [4];
   logic [14:0] strobe_q [$];
   logic [14:0] exp_strobe_q [$];
   int          wide_strobes = 0;
   logic        prev_strobe = 1'b0;

   // Records each strobe with the register value visible in the same cycle.
   always @(negedge clk) begin
      if (wr_strobe) strobe_q.push_back({wr_addr, regs[int'(wr_addr)*8 +: 8]});
      if (wr_strobe && prev_strobe) wide_strobes <= wide_strobes + 1;
      prev_strobe <= wr_strobe;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = '0;
      for (int i = 0; i < nbits; i++) begin
         mosi = tx[7-i];
         wait_clk(HALF);
         rx[7-i] = miso;
         sclk = 1'b1;
         wait_clk(HALF);
         sclk = 1'b0;
      end
   endtask

   function automatic logic [NR*8-1:0] model_flat();
      logic [NR*8-1:0] f;
      for (int k = 0; k < NR; k++) f[k*8 +: 8] = model[k];
      return f;
   endfunction

   task automatic check_state(input string tag);
      check({tag, "_strobe_count"}, strobe_q.size(), exp_strobe_q.size());
      for (int i = 0; i < strobe_q.size() && i < exp_strobe_q.size(); i++)
         check({tag, "_strobe_entry"}, strobe_q[i], exp_strobe_q[i]);
      strobe_q.delete();
      exp_strobe_q.delete();
      check({tag, "_regs"}, regs, model_flat());
   endtask

   task automatic cs_begin();
      cs_n = 1'b0;
      wait_clk(HALF);
      check("oe_selected", miso_oe, 1'b1);
   endtask

   task automatic cs_end();
      mosi = 1'b0;
      wait_clk(HALF);
      cs_n = 1'b1;
      wait_clk(2 * HALF);
      check("oe_deselected", miso_oe, 1'b0);
      check("miso_deselected", miso, 1'b0);
   endtask

   // Full transaction: command byte then nbytes from buf_d, with the model applying burst rules.
   task automatic run_txn(input string tag, input logic [7:0] cmd, input int nbytes);
      logic [7:0] rx;
      logic [7:0] exp;
      logic [6:0] a;
      a = cmd[6:0];
      cs_begin();
      xfer(cmd, 8, rx);
      check({tag, "_cmd_miso"}, rx, 8'h00);
      for (int i = 0; i < nbytes; i++) begin
         xfer(buf_d[i], 8, rx);
         if (cmd[7]) begin
            exp = 8'h00;
            if (int'(a) < NR) begin
               model[a] = buf_d[i];
               exp_strobe_q.push_back({a, buf_d[i]});
            end
         end else begin
            exp = (int'(a) < NR) ? model[a] : 8'h00;
         end
         check({tag, cmd[7] ? "_wr_miso" : "_rd_miso"}, rx, exp);
         a = a + 7'd1;
      end
      cs_end();
      check_state(tag);
   endtask

   initial begin
      logic [7:0] rx;
      logic [6:0] ra;
      logic       rw;
      int         n;

      for (int k = 0; k < 128; k++) model[k] = 8'h00;

      // Reset with pins idle.
      wait_clk(3);
      check("rst_regs", regs, '0);
      check("rst_oe", miso_oe, 1'b0);
      check("rst_miso", miso, 1'b0);
      check("rst_strobe", wr_strobe, 1'b0);
      check("rst_wr_addr", wr_addr, 7'd0);
      rst_n = 1'b1;
      wait_clk(12);
      check("idle_oe", miso_oe, 1'b0);

      buf_d[0] = 8'hA5;
      run_txn("wr3", 8'h83, 1);
      buf_d[0] = 8'h00;
      run_txn("rd3", 8'h03, 1);

      buf_d[0] = 8'h11; buf_d[1] = 8'h22; buf_d[2] = 8'h33;
      run_txn("burst_wr", 8'h86, 3);
      run_txn("burst_rd", 8'h06, 3);

      run_txn("rd_oob", 8'h7F, 1);
      buf_d[0] = 8'h5A;
      run_txn("wr_oob", 8'hFF, 1);

      // Deselect after 5 data bits: partial byte must vanish.
      cs_begin();
      xfer(8'h82, 8, rx);
      xfer(8'hC3, 5, rx);
      wait_clk(HALF);
      cs_n = 1'b1;
      wait_clk(2 * HALF);
      check_state("abort");
      buf_d[0] = 8'h3C;
      run_txn("wr2", 8'h82, 1);

      for (int t = 0; t < 24; t++) begin
         if ($urandom_range(0, 3) == 0) ra = 7'(124 + $urandom_range(0, 3));
         else ra = 7'($urandom_range(0, 11));
         rw = 1'($urandom_range(0, 1));
         n = int'($urandom_range(1, 3));
         for (int i = 0; i < 4; i++) buf_d[i] = 8'($urandom);
         run_txn("rand", {rw, ra}, n);
      end

      // Reset in the middle of a read burst with cs_n still low.
      buf_d[0] = 8'h77;
      run_txn("wr1", 8'h81, 1);
      cs_n = 1'b0;
      wait_clk(HALF);
      xfer(8'h01, 8, rx);
      xfer(8'h00, 8, rx);
      check("pre_rst_read", rx, model[1]);
      xfer(8'h00, 4, rx);
      rst_n = 1'b0;
      wait_clk(2);
      for (int k = 0; k < 128; k++) model[k] = 8'h00;
      check("mid_rst_regs", regs, '0);
      check("mid_rst_oe", miso_oe, 1'b0);
      check("mid_rst_miso", miso, 1'b0);
      check("mid_rst_strobe", wr_strobe, 1'b0);
      check("mid_rst_wr_addr", wr_addr, 7'd0);
      rst_n = 1'b1;
      wait_clk(4 * HALF);
      check("post_rst_no_frame_oe", miso_oe, 1'b0);
      cs_n = 1'b1;
      wait_clk(2 * HALF);
      strobe_q.delete();
      exp_strobe_q.delete();
      buf_d[0] = 8'h00;
      run_txn("post_rst_rd1", 8'h01, 1);

      check("strobe_width", wide_strobes, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tt_spi_reg_target.md
# tt_spi_reg_target

SPI mode-0 target (responder) with a small register file, placed inside the TinyTapeout tile behind the dedicated pins. It answers transactions from the demo-board SPI initiator and exposes the registers to the design core as flat configuration outputs. SPI lines are asynchronous to `clk` and are oversampled: each is synchronized and edge-detected in the `clk` domain.

## Interface
- `NUM_REGS`, 8: number of 8-bit registers, 1..128.
- `SYNC_STAGES`, 2: synchronizer depth for `sclk_i`, `cs_n_i`, `mosi_i`; minimum 2.
- `clk`  in  1  system clock; all state on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sclk_i`  in  1  SPI clock from initiator (idle low).
- `cs_n_i`  in  1  chip select, active low.
- `mosi_i`  in  1  serial data in, MSB first.
- `miso_o`  out  1  serial data out, MSB first.
- `miso_oe_o`  out  1  output enable for the MISO pin (maps to a `uio_oe` bit).
- `regs_o`  out  NUM_REGS*8  register contents; reg k at bits [8k+7:8k].
- `wr_strobe_o`  out  1  one-cycle pulse when a register is written.
- `wr_addr_o`  out  7  address of the write flagged by `wr_strobe_o`.

## Operation
- States: IDLE, CMD, DATA.
- IDLE -> CMD on synchronized `cs_n` falling edge; bit counter = 0.
- Bits sampled on synchronized `sclk` rising edge, shifted in MSB first.
- CMD: after 8 bits, byte = {rw, addr[6:0]}; rw=1 write, rw=0 read; -> DATA, current address = addr.
- DATA, read: on entry and at each byte boundary, shift-out register loads reg[cur_addr] (0x00 if cur_addr >= NUM_REGS); bit 7 driven on `miso_o` immediately; later bits advance on synchronized `sclk` falling edge.
- DATA, write: after 8 bits, if cur_addr < NUM_REGS, reg[cur_addr] <= byte, `wr_strobe_o` pulses, `wr_addr_o` = cur_addr; out-of-range writes are discarded with no strobe.
- After every data byte cur_addr increments modulo 128 (burst access); stays in DATA.
- MISO during CMD phase and during write bursts: 0.
- `miso_oe_o` = 1 exactly while synchronized `cs_n` is low; `miso_o` = 0 whenever `miso_oe_o` = 0.
- `cs_n` rising (any state, any bit count) -> IDLE; partial byte discarded, no write, no strobe.
- Same-cycle `cs_n` rising and `sclk` rising: `cs_n` wins, the edge is ignored.
- Reset: all registers 0x00, state IDLE, `miso_o`=0, `miso_oe_o`=0, `wr_strobe_o`=0, `wr_addr_o`=0. Reset mid-transaction aborts it; the next transaction starts only after a fresh `cs_n` falling edge.

## Timing
- Input-to-detect latency: SYNC_STAGES+1 `clk` cycles from pin edge to internal edge pulse.
- Requirements: `sclk` high and low phases each >= 4 `clk` cycles (f_sclk <= f_clk/8); `cs_n` low >= 4 `clk` before first `sclk` rise; `cs_n` high >= 4 `clk` between transactions.
- Read: first data bit valid on `miso_o` 1 `clk` after the detected 8th command rising edge, i.e. well before the 9th `sclk` rise; subsequent bits change 1 `clk` after the detected falling edge.
- Write: `regs_o` updates and `wr_strobe_o` asserts on the same `clk` edge, 1 `clk` after the detected 8th data rising edge; strobe is exactly 1 cycle.
- `regs_o` is registered; no combinational path from any SPI pin to any output.

## Structure
- Package `tt_spi_pkg`: state enum (IDLE, CMD, DATA), `RW_BIT` = 7, `ADDR_W` = 7, `BYTE_W` = 8.
- Sub-module `spi_sync_edge`: SYNC_STAGES flop chain plus rise/fall pulse outputs; instantiated for `sclk_i` and `cs_n_i`; `mosi_i` uses the same module with edge outputs unused.
- Top holds FSM, bit counter, shift-in/out registers, address counter, register array.

## Test plan
- Reset with pins idle -> all `regs_o` 0, `miso_oe_o`=0, `miso_o`=0, no strobe.
- Write 0x83, 0xA5 -> reg3 = 0xA5, one strobe with `wr_addr_o`=3; read 0x03 then 8 clocks -> MISO shifts 0xA5.
- Burst write 0x86, 0x11, 0x22, 0x33 (NUM_REGS=8) -> reg6=0x11, reg7=0x22, third byte at addr 8 discarded, exactly 2 strobes.
- Read 0x7F (out of range) -> MISO returns 0x00; write 0xFF, 0x5A -> no strobe, no register changes.
- Write 0x82 then raise `cs_n` after 5 data bits -> reg2 unchanged, no strobe; next full write 0x82, 0x3C succeeds.
- Assert `rst_n` low mid-read-burst with reg1=0x77 -> all registers 0, outputs at reset values; a following read of 0x01 returns 0x00.
